trdb_packet_scheduler: RTL
==========================

# trdb_packet_scheduler

Sequencing stage between the packet identifier (trdb_priority) and the packet emitter. It queues packet descriptors from the identifier and from trigger-unit format 2 requests in a small FIFO, and presents them one at a time to the emitter over a valid/ready handshake. It owns the resync counter that drives the identifier's `tc_max_resync_i`, and the packets-lost flag that drives its `tc_packets_lost_i`.

## Interface
- `DEPTH`, 4: descriptor FIFO entries; power of two, ≥2.
- `RESYNC_MAX`, 16'd256: qualified-cycle count at which a resync is requested.
- `CNT_W`, 16: resync counter width; `RESYNC_MAX < 2**CNT_W`.
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `pkt_valid_i` in 1: descriptor request from the identifier this cycle.
- `pkt_format_i` in trdb_format_e (2): requested format.
- `pkt_subformat_i` in trdb_f_sync_subformat_e (2): sync subformat; ignored unless format is F_SYNC.
- `pkt_thaddr_i` in 1: thaddr value for the packet.
- `pkt_cause_mux_i` in 1: 0 = lc cause, 1 = tc cause.
- `trig_req_i` in 1: trigger unit requests a format 2 packet (trigger value 4).
- `qualified_i` in 1: instruction qualified this cycle.
- `out_valid_o` out 1: head descriptor valid.
- `out_ready_i` in 1: emitter accepts the head.
- `out_desc_o` out trdb_pkt_desc_t: head descriptor (format, subformat, thaddr, cause_mux, src).
- `fifo_count_o` out $clog2(DEPTH+1): occupancy.
- `max_resync_o` out 1: resync counter reached RESYNC_MAX.
- `packets_lost_o` out 1: at least one descriptor dropped since the last accepted F_SYNC/SF_SUPPORT.

## Operation
- Dequeue fires when `out_valid_o && out_ready_i`.
- At most one enqueue per cycle.
  - If `pkt_valid_i` is high, the identifier descriptor is enqueued with src=0.
  - Otherwise, if a trigger request is pending, a trigger descriptor is enqueued: format F_ADDR_ONLY, subformat SF_START, thaddr 0, cause_mux 0, src=1.
- Trigger pending flag:
  - Set by `trig_req_i`.
  - Cleared when its descriptor is enqueued.
  - Further `trig_req_i` pulses while the flag is set merge into the one request; this is not counted as a loss.
  - A `trig_req_i` arriving in the same cycle as its own enqueue re-sets the flag.
- An enqueue is permitted when `fifo_count_o < DEPTH`, or when the FIFO is full and a dequeue fires in the same cycle.
- If an identifier descriptor cannot be enqueued, it is dropped and `packets_lost_o` is set.
  - A pending trigger request is never dropped; it waits for space.
- `packets_lost_o` clear: it clears when the dequeued descriptor is F_SYNC/SF_SUPPORT.
- `packets_lost_o` priority: if a drop and that clearing dequeue happen in the same cycle, set wins.
- Resync counter:
  - Increments on `qualified_i`.
  - Saturates at RESYNC_MAX.
  - Clears to 0 when the dequeued descriptor is F_SYNC with SF_START or SF_TRAP.
  - If a clear and an increment happen in the same cycle, clear wins and the result is 0.
- `max_resync_o` = (cnt == RESYNC_MAX).

## Timing
- Reset values: `out_valid_o`=0, `out_desc_o`='0, `fifo_count_o`=0, `max_resync_o`=0, `packets_lost_o`=0. The pending flag and counter are also 0.
- Reset asserted mid-operation empties the FIFO on the next edge; in-flight descriptors are discarded.
- Enqueue at edge N: `out_valid_o` is high after edge N when the FIFO was empty. Latency is 1 cycle and there is no bypass path.
- `out_desc_o` is stable while `out_valid_o && !out_ready_i`.
- Simultaneous enqueue and dequeue: `fifo_count_o` is unchanged.
- Read and write pointers wrap modulo DEPTH.
- Counter and flag update on the same edge as the dequeue that affects them. `max_resync_o` is registered and deasserts the cycle after the clearing dequeue.

## Structure
- trdb_pkg:
  - Add `trdb_pkt_desc_t`, a packed struct: format, subformat, thaddr, cause_mux, src.
  - Add constant `TRDB_TRIG_FMT2` = 4.
  - Reuse the existing `trdb_format_e` and `trdb_f_sync_subformat_e`.
- Sub-module `trdb_desc_fifo`:
  - Generic synchronous FIFO, parameterised on DEPTH and element type.
  - Provides full/empty/count.
  - Allows push when full if pop is asserted.
- Arbitration, pending flag, loss flag and resync counter live in the top module.

## Test plan
- Reset, then one `pkt_valid_i` with F_SYNC/SF_TRAP, `out_ready_i`=1 → `out_valid_o` high for exactly 1 cycle after the enqueue edge with src=0, `fifo_count_o` 1→0.
- `pkt_valid_i` and `trig_req_i` in the same cycle → identifier descriptor first, then F_ADDR_ONLY with src=1 one cycle later. Three extra `trig_req_i` while pending → still exactly one trigger descriptor.
- `out_ready_i`=0 with 5 identifier requests at DEPTH=4 → `fifo_count_o`=4, `packets_lost_o`=1 from the 5th. Later dequeue of F_SYNC/SF_SUPPORT → `packets_lost_o`=0.
- FIFO full with `out_ready_i`=1 and `pkt_valid_i`=1 in the same cycle → no drop, count stays 4.
- RESYNC_MAX=8 with 8 qualified cycles → `max_resync_o`=1 and it holds through extra qualified cycles. Dequeue F_SYNC/SF_START together with `qualified_i`=1 → counter 0, `max_resync_o`=0.
- `rst_ni` low with 3 entries queued and trigger pending → next cycle all outputs 0, and no trigger descriptor is emitted after reset.

Source files
------------

// File: rtl/trdb_pkg.sv
// Shared types for the trace debugger packet path: packet formats,
// sync subformats and the scheduler's queued packet descriptor.
package trdb_pkg;

   typedef enum logic [1:0] {
      F_OPT_EXT   = 2'h0,
      F_DIFF_ADDR = 2'h1,
      F_ADDR_ONLY = 2'h2,
      F_SYNC      = 2'h3
   } trdb_format_e;

   typedef enum logic [1:0] {
      SF_START   = 2'h0,
      SF_TRAP    = 2'h1,
      SF_CONTEXT = 2'h2,
      SF_SUPPORT = 2'h3
   } trdb_f_sync_subformat_e;

   // Trigger unit value that asks for a format 2 (address only) packet
   localparam logic [2:0] TRDB_TRIG_FMT2 = 3'd4;

   // One queued packet request; src = 0 identifier, 1 trigger unit
   typedef struct packed {
      trdb_format_e           format;
      trdb_f_sync_subformat_e subformat;
      logic                   thaddr;
      logic                   cause_mux;
      logic                   src;
   } trdb_pkt_desc_t;

endpackage

// File: rtl/trdb_desc_fifo.sv
// Generic synchronous FIFO. Push while full is accepted when a pop
// happens on the same edge. Output reads as '0 while empty.
module trdb_desc_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [7:0]
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  T                           data_i,
   input  logic                       pop_i,
   output T                           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   T                mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            do_push;
   logic            do_pop;

   assign empty_o = (count == '0);
   assign full_o  = (count == CW'(DEPTH));
   assign count_o = count;
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = empty_o ? '0 : mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   // Storage needs no reset; empty gating hides stale entries
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= data_i;
   end

endmodule

// File: rtl/trdb_packet_scheduler.sv
// Queues packet requests from the identifier and the trigger unit and
// hands them to the emitter one at a time. Also owns the resync counter
// and the packets-lost flag fed back to the identifier.
module trdb_packet_scheduler
   import trdb_pkg::*;
#(
   parameter int              DEPTH      = 4,
   parameter int              CNT_W      = 16,
   parameter logic [CNT_W-1:0] RESYNC_MAX = 16'd256
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       pkt_valid_i,
   input  trdb_format_e               pkt_format_i,
   input  trdb_f_sync_subformat_e     pkt_subformat_i,
   input  logic                       pkt_thaddr_i,
   input  logic                       pkt_cause_mux_i,
   input  logic                       trig_req_i,
   input  logic                       qualified_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output trdb_pkt_desc_t             out_desc_o,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
   output logic                       max_resync_o,
   output logic                       packets_lost_o
);

   localparam trdb_pkt_desc_t TRIG_DESC = '{
      format:    F_ADDR_ONLY,
      subformat: SF_START,
      thaddr:    1'b0,
      cause_mux: 1'b0,
      src:       1'b1
   };

   logic           full, empty;
   logic           deq, can_enq, enq_trig, push, drop;
   logic           clr_lost, clr_cnt;
   logic           trig_pend_q, lost_q;
   logic [CNT_W-1:0] cnt_q;
   trdb_pkt_desc_t push_desc;

   assign out_valid_o    = !empty;
   assign deq            = out_valid_o && out_ready_i;
   assign can_enq        = !full || deq;
   assign drop           = pkt_valid_i && !can_enq;
   assign enq_trig       = !pkt_valid_i && trig_pend_q && can_enq;
   assign clr_lost       = deq && out_desc_o.format == F_SYNC
                           && out_desc_o.subformat == SF_SUPPORT;
   assign clr_cnt        = deq && out_desc_o.format == F_SYNC
                           && (out_desc_o.subformat == SF_START
                               || out_desc_o.subformat == SF_TRAP);
   assign packets_lost_o = lost_q;
   assign max_resync_o   = (cnt_q == RESYNC_MAX);

   // Identifier request wins the single enqueue slot over a pending trigger
   always_comb begin
      push      = 1'b0;
      push_desc = TRIG_DESC;
      if (pkt_valid_i) begin
         push      = can_enq;
         push_desc = '{format:    pkt_format_i,
                       subformat: pkt_subformat_i,
                       thaddr:    pkt_thaddr_i,
                       cause_mux: pkt_cause_mux_i,
                       src:       1'b0};
      end else if (enq_trig) begin
         push = 1'b1;
      end
   end

   trdb_desc_fifo #(
      .DEPTH (DEPTH),
      .T     (trdb_pkt_desc_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (push_desc),
      .pop_i   (out_ready_i),
      .data_o  (out_desc_o),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_count_o)
   );

   // Trigger pending: repeat requests merge, a new one re-arms on enqueue
   always_ff @(posedge clk_i) begin
      if (!rst_ni)         trig_pend_q <= 1'b0;
      else if (trig_req_i) trig_pend_q <= 1'b1;
      else if (enq_trig)   trig_pend_q <= 1'b0;
   end

   // Loss flag: a drop in the same cycle as the clearing dequeue keeps it set
   always_ff @(posedge clk_i) begin
      if (!rst_ni)       lost_q <= 1'b0;
      else if (drop)     lost_q <= 1'b1;
      else if (clr_lost) lost_q <= 1'b0;
   end

   // Saturating resync counter; a sync start/trap dequeue overrides counting
   always_ff @(posedge clk_i) begin
      if (!rst_ni)      cnt_q <= '0;
      else if (clr_cnt) cnt_q <= '0;
      else if (qualified_i && cnt_q != RESYNC_MAX) cnt_q <= cnt_q + 1'b1;
   end

endmodule
